// File: rtl/packet_arbitration_multiplexer.sv
// Packet-locked N:1 multiplexer driven by an external priority arbiter, one-entry output register.
// Optional PACKET_ARBITRATION_MULTIPLEXER_BYPASS_EN accepts the first beat in the grant cycle.
module packet_arbitration_multiplexer #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SIZE-1:0]         input_valid,
    output logic [SIZE-1:0]         input_ready,
    input  logic [SIZE*WIDTH-1:0]   input_data,
    input  logic [SIZE-1:0]         input_last,
    output logic [SIZE-1:0]         arbiter_requests,
    input  logic [SIZE-1:0]         arbiter_grant,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [WIDTH-1:0]        output_data,
    output logic                    output_last,
    output logic [$clog2(SIZE)-1:0] output_source
);

    localparam int unsigned IdxW = $clog2(SIZE);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic            valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic            last_q, last_d;
    logic [IdxW-1:0] source_q, source_d;

    logic [SIZE-1:0] masked_grant;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW-1:0] sel;
    logic            can_accept;
    logic            accept;

    // Grants for channels without a valid beat are dropped; lowest surviving bit wins.
    always_comb begin
        masked_grant = arbiter_grant & input_valid;
        grant_idx    = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (masked_grant[i]) begin
                grant_idx = IdxW'(i);
            end
        end
    end

    assign can_accept = !valid_q || output_ready;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        arbiter_requests = '0;
        input_ready      = '0;
        accept           = 1'b0;
        sel              = owner_q;
        case (state_q)
            StIdle: begin
                arbiter_requests = input_valid;
                if (masked_grant != '0) begin
                    owner_d = grant_idx;
                    sel     = grant_idx;
                    state_d = StLocked;
`ifdef PACKET_ARBITRATION_MULTIPLEXER_BYPASS_EN
                    if (can_accept) begin
                        input_ready[grant_idx] = 1'b1;
                        accept                 = 1'b1;
                        if (input_last[grant_idx]) begin
                            state_d = StIdle;
                        end
                    end
`endif
                end
            end
            StLocked: begin
                input_ready[owner_q] = can_accept;
                accept               = can_accept && input_valid[owner_q];
                if (accept && input_last[owner_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Nothing is handshaken while reset is applied, so an in-flight packet is abandoned.
        if (reset) begin
            input_ready = '0;
            accept      = 1'b0;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;
        source_d = source_q;
        if (accept) begin
            valid_d  = 1'b1;
            data_d   = input_data[sel*WIDTH +: WIDTH];
            last_d   = input_last[sel];
            source_d = sel;
        end else if (output_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            source_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            source_q <= source_d;
        end
    end

    assign output_valid  = valid_q;
    assign output_data   = data_q;
    assign output_last   = last_q;
    assign output_source = source_q;

endmodule

// File: tb/tb_packet_arbitration_multiplexer.sv
// Directed bench for packet_arbitration_multiplexer: handshake-following sources, negedge beat log.
// Expected latencies follow PACKET_ARBITRATION_MULTIPLEXER_BYPASS_EN when it is defined.
module tb_packet_arbitration_multiplexer;

`ifdef PACKET_ARBITRATION_MULTIPLEXER_BYPASS_EN
    localparam int Lat = 1;
    localparam int Gap = 1;
`else
    localparam int Lat = 2;
    localparam int Gap = 2;
`endif

    logic        clock;
    logic        reset;
    logic [3:0]  input_valid;
    logic [3:0]  input_ready;
    logic [31:0] input_data;
    logic [3:0]  input_last;
    logic [3:0]  arbiter_requests;
    logic [3:0]  arbiter_grant;
    logic        output_valid;
    logic        output_ready;
    logic [7:0]  output_data;
    logic        output_last;
    logic [1:0]  output_source;

    packet_arbitration_multiplexer #(
        .SIZE (4),
        .WIDTH(8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .input_valid     (input_valid),
        .input_ready     (input_ready),
        .input_data      (input_data),
        .input_last      (input_last),
        .arbiter_requests(arbiter_requests),
        .arbiter_grant   (arbiter_grant),
        .output_valid    (output_valid),
        .output_ready    (output_ready),
        .output_data     (output_data),
        .output_last     (output_last),
        .output_source   (output_source)
    );

    typedef struct {
        int         cyc;
        int         src;
        bit         last;
        logic [7:0] data;
    } beat_t;

    beat_t      q[$];
    int         len[4];
    int         idx[4];
    logic [7:0] base[4];
    bit         single[4];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         gcyc;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel c offers beat k as base + k*0x11; last on the final beat (or every beat if single).
    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            input_valid[c]       = idx[c] < len[c];
            input_data[c*8 +: 8] = base[c] + 8'(idx[c] * 17);
            input_last[c]        = single[c] || (idx[c] == len[c] - 1);
        end
    endtask

    task automatic load(input int c, input int l, input logic [7:0] b, input bit s);
        len[c]    = l;
        idx[c]    = 0;
        base[c]   = b;
        single[c] = s;
    endtask

    task automatic step();
        logic [3:0] acc;
        beat_t      b;
        @(negedge clock);
        acc = input_valid & input_ready;
        if (!reset && output_valid && output_ready) begin
            b.cyc  = cyc;
            b.src  = int'(output_source);
            b.last = output_last;
            b.data = output_data;
            q.push_back(b);
        end
        @(posedge clock);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (acc[c]) idx[c]++;
        end
        drive();
        #1;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && q.size() < n; i++) step();
        chk(tag, q.size(), n);
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [7:0] d, input int s,
                            input bit l);
        if (i < q.size()) begin
            chk({tag, " data"}, q[i].data, d);
            chk({tag, " src"}, q[i].src, s);
            chk({tag, " last"}, q[i].last, l);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 4; c++) load(c, 0, 8'h00, 1'b0);
        reset         = 1'b1;
        output_ready  = 1'b1;
        load(0, 1, 8'hE0, 1'b0);
        load(2, 1, 8'hE2, 1'b0);
        arbiter_grant = 4'b0101;
        drive();
        step();
        step();
        chk("reset input_ready", input_ready, 4'b0000);
        chk("reset output_valid", output_valid, 1'b0);
        chk("reset output_data", output_data, 8'h00);
        chk("reset output_last", output_last, 1'b0);
        chk("reset output_source", output_source, 2'd0);
        reset         = 1'b0;
        arbiter_grant = 4'b0000;
        load(0, 0, 8'h00, 1'b0);
        load(2, 0, 8'h00, 1'b0);
        drive();
        step();
        q.delete();

        // 3-beat packet on channel 2
        load(2, 3, 8'h11, 1'b0);
        drive();
        arbiter_grant = 4'b0100;
        #1;
        chk("t1 idle requests", arbiter_requests, 4'b0100);
        gcyc = cyc;
        step();
        arbiter_grant = 4'b0000;
        #1;
        chk("t1 locked requests", arbiter_requests, 4'b0000);
        wait_beats("t1 beat count", 3, 10);
        chk_beat("t1 b0", 0, 8'h11, 2, 1'b0);
        chk_beat("t1 b1", 1, 8'h22, 2, 1'b0);
        chk_beat("t1 b2", 2, 8'h33, 2, 1'b1);
        if (q.size() == 3) begin
            chk("t1 latency", q[0].cyc - gcyc, Lat);
            chk("t1 spacing", q[2].cyc - q[0].cyc, 2);
        end
        load(3, 1, 8'h5A, 1'b0);
        drive();
        #1;
        chk("t1 back to idle", arbiter_requests, 4'b1000);
        load(3, 0, 8'h00, 1'b0);
        drive();
        step();
        q.delete();

        // Channel 1 granted, channel 0 granted mid-packet
        load(1, 3, 8'h40, 1'b0);
        load(0, 2, 8'hA0, 1'b0);
        drive();
        #1;
        chk("t2 idle requests", arbiter_requests, 4'b0011);
        arbiter_grant = 4'b0010;
        step();
        arbiter_grant = 4'b0001;
        #1;
        chk("t2 locked requests a", arbiter_requests, 4'b0000);
        step();
        chk("t2 locked requests b", arbiter_requests, 4'b0000);
        wait_beats("t2 beat count", 5, 20);
        chk_beat("t2 b0", 0, 8'h40, 1, 1'b0);
        chk_beat("t2 b1", 1, 8'h51, 1, 1'b0);
        chk_beat("t2 b2", 2, 8'h62, 1, 1'b1);
        chk_beat("t2 b3", 3, 8'hA0, 0, 1'b0);
        chk_beat("t2 b4", 4, 8'hB1, 0, 1'b1);
        if (q.size() == 5) chk("t2 no bubble", q[2].cyc - q[0].cyc, 2);
        arbiter_grant = 4'b0000;
        step();
        q.delete();

        // Output stall for 4 cycles mid-packet on channel 3
        load(3, 4, 8'h05, 1'b0);
        drive();
        arbiter_grant = 4'b1000;
        step();
        arbiter_grant = 4'b0000;
        wait_beats("t3 first beat", 1, 10);
        output_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t3 stall valid", output_valid, 1'b1);
            chk("t3 stall data", output_data, 8'h16);
            chk("t3 stall ready", input_ready, 4'b0000);
            step();
        end
        output_ready = 1'b1;
        #1;
        wait_beats("t3 beat count", 4, 12);
        chk_beat("t3 b0", 0, 8'h05, 3, 1'b0);
        chk_beat("t3 b1", 1, 8'h16, 3, 1'b0);
        chk_beat("t3 b2", 2, 8'h27, 3, 1'b0);
        chk_beat("t3 b3", 3, 8'h38, 3, 1'b1);
        step();
        chk("t3 no duplicate", q.size(), 4);
        q.delete();

        // Grant for a non-valid channel is ignored
        load(1, 1, 8'h77, 1'b0);
        drive();
        arbiter_grant = 4'b1000;
        #1;
        chk("t4 requests", arbiter_requests, 4'b0010);
        step();
        chk("t4 still idle", arbiter_requests, 4'b0010);
        chk("t4 no output", output_valid, 1'b0);
        load(0, 1, 8'h99, 1'b0);
        drive();
        arbiter_grant = 4'b0011;
        wait_beats("t4 beat count", 2, 12);
        chk_beat("t4 b0", 0, 8'h99, 0, 1'b1);
        chk_beat("t4 b1", 1, 8'h77, 1, 1'b1);
        arbiter_grant = 4'b0000;
        step();
        q.delete();

        // Reset on the second beat of a 4-beat packet
        load(2, 4, 8'h10, 1'b0);
        drive();
        arbiter_grant = 4'b0100;
        step();
        arbiter_grant = 4'b0000;
        wait_beats("t5 first beat", 1, 10);
        chk("t5 second beat held", output_data, 8'h21);
        reset = 1'b1;
        #1;
        chk("t5 ready in reset", input_ready, 4'b0000);
        step();
        reset = 1'b0;
        #1;
        chk("t5 valid cleared", output_valid, 1'b0);
        chk("t5 data cleared", output_data, 8'h00);
        chk("t5 source cleared", output_source, 2'd0);
        chk("t5 idle", arbiter_requests, 4'b0100);
        for (int i = 0; i < 4; i++) step();
        chk("t5 no more beats", q.size(), 1);
        chk("t5 output quiet", output_valid, 1'b0);
        load(2, 0, 8'h00, 1'b0);
        drive();
        step();
        q.delete();

        // Back-to-back single-beat packets on channel 1
        load(1, 4, 8'h30, 1'b1);
        drive();
        arbiter_grant = 4'b0010;
        wait_beats("t6 beat count", 4, 20);
        chk_beat("t6 b0", 0, 8'h30, 1, 1'b1);
        chk_beat("t6 b1", 1, 8'h41, 1, 1'b1);
        chk_beat("t6 b2", 2, 8'h52, 1, 1'b1);
        chk_beat("t6 b3", 3, 8'h63, 1, 1'b1);
        if (q.size() == 4) begin
            for (int i = 0; i < 3; i++) chk("t6 gap", q[i+1].cyc - q[i].cyc, Gap);
        end
        arbiter_grant = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
